// File: rtl/llmanager_refcount_mp.sv
// Multi-port pipelined refcount manager: round-robin deref issue (S0 read), decrement/write (S1)
// with same-page forwarding, underflow flagging and a reclaim FIFO toward the free-list manager.
module llmanager_refcount_mp #(
  parameter int lpsz    = 8,
  parameter int refsz   = 3,
  parameter int ports   = 4,
  parameter int portsz  = 2,
  parameter int rcdepth = 4,
  parameter int rcasz   = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ports-1:0]        drq_srdy,
  output logic [ports-1:0]        drq_drdy,
  input  logic [ports*lpsz-1:0]   drq_start_page,
  input  logic [ports*lpsz-1:0]   drq_end_page,
  output logic                    reclaim_srdy,
  input  logic                    reclaim_drdy,
  output logic [lpsz-1:0]         reclaim_start_page,
  output logic [lpsz-1:0]         reclaim_end_page,
  input  logic                    refup_srdy,
  output logic                    refup_drdy,
  input  logic [lpsz-1:0]         refup_page,
  input  logic [refsz-1:0]        refup_count,
  output logic                    ref_wr_en,
  output logic [lpsz-1:0]         ref_wr_addr,
  output logic [refsz-1:0]        ref_wr_data,
  output logic                    ref_rd_en,
  output logic [lpsz-1:0]         ref_rd_addr,
  input  logic [refsz-1:0]        ref_rd_data,
  output logic                    deref_err,
  output logic [portsz-1:0]       deref_err_port
);

  logic [lpsz-1:0]   start_a [ports];
  logic [lpsz-1:0]   end_a   [ports];

  logic              s1_vld_q, fwd_vld_q;
  logic [lpsz-1:0]   s1_start_q, s1_end_q;
  logic [portsz-1:0] s1_port_q, rr_q;
  logic [refsz-1:0]  fwd_data_q;

  logic [lpsz-1:0]   rc_start_mem [rcdepth];
  logic [lpsz-1:0]   rc_end_mem   [rcdepth];
  logic [rcasz-1:0]  rc_wr_q, rc_rd_q;
  logic [rcasz:0]    rc_cnt_q, rc_cnt_d;

  logic              gnt_vld, room, issue, refup_xfer;
  logic [portsz-1:0] gnt_idx, gnt_nxt;
  logic [rcasz+1:0]  occ;
  logic [refsz-1:0]  cur, new_cnt;
  logic              cur_zero, s1_wr, push, pop;

  always_comb begin
    for (int i = 0; i < ports; i++) begin
      start_a[i] = drq_start_page[i*lpsz +: lpsz];
      end_a[i]   = drq_end_page[i*lpsz +: lpsz];
    end
  end

  // Round-robin: first requester at or after rr_q, then wrap to the lower indices.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int i = 0; i < ports; i++) begin
      if (!gnt_vld && drq_srdy[i] && (i >= int'(rr_q))) begin
        gnt_vld = 1'b1;
        gnt_idx = portsz'(i);
      end
    end
    for (int i = 0; i < ports; i++) begin
      if (!gnt_vld && drq_srdy[i]) begin
        gnt_vld = 1'b1;
        gnt_idx = portsz'(i);
      end
    end
    gnt_nxt = (gnt_idx == portsz'(ports - 1)) ? '0 : gnt_idx + portsz'(1);
  end

  // Every in-flight S1 may still push, so it is counted against FIFO space.
  assign occ        = {1'b0, rc_cnt_q} + {{(rcasz+1){1'b0}}, s1_vld_q};
  assign room       = occ < (rcasz+2)'(rcdepth);
  assign refup_drdy = reset & ~s1_vld_q;
  assign refup_xfer = refup_srdy & refup_drdy;
  assign issue      = reset & ~refup_xfer & gnt_vld & room;

  always_comb begin
    drq_drdy = '0;
    if (issue) drq_drdy[gnt_idx] = 1'b1;
  end

  assign ref_rd_en   = issue;
  assign ref_rd_addr = issue ? start_a[gnt_idx] : '0;

  assign cur      = fwd_vld_q ? fwd_data_q : ref_rd_data;
  assign cur_zero = (cur == '0);
  assign new_cnt  = cur_zero ? cur : cur - refsz'(1);
  assign s1_wr    = s1_vld_q & ~cur_zero;
  assign push     = s1_wr & (cur == refsz'(1));

  assign deref_err      = s1_vld_q & cur_zero;
  assign deref_err_port = deref_err ? s1_port_q : '0;

  // S1 never overlaps a refup since refup_drdy requires an empty S1.
  assign ref_wr_en   = refup_xfer | s1_wr;
  assign ref_wr_addr = refup_xfer ? refup_page  : (s1_wr ? s1_start_q : '0);
  assign ref_wr_data = refup_xfer ? refup_count : (s1_wr ? new_cnt    : '0);

  assign reclaim_srdy       = (rc_cnt_q != '0);
  assign pop                = reclaim_srdy & reclaim_drdy;
  assign reclaim_start_page = reclaim_srdy ? rc_start_mem[rc_rd_q] : '0;
  assign reclaim_end_page   = reclaim_srdy ? rc_end_mem[rc_rd_q]   : '0;

  always_comb begin
    rc_cnt_d = rc_cnt_q;
    if (push && !pop)      rc_cnt_d = rc_cnt_q + (rcasz+1)'(1);
    else if (pop && !push) rc_cnt_d = rc_cnt_q - (rcasz+1)'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_vld_q  <= 1'b0;
      fwd_vld_q <= 1'b0;
      rr_q      <= '0;
      rc_wr_q   <= '0;
      rc_rd_q   <= '0;
      rc_cnt_q  <= '0;
    end else begin
      s1_vld_q  <= issue;
      fwd_vld_q <= issue & s1_vld_q & (start_a[gnt_idx] == s1_start_q);
      if (issue) rr_q <= gnt_nxt;
      if (push)  rc_wr_q <= rc_wr_q + rcasz'(1);
      if (pop)   rc_rd_q <= rc_rd_q + rcasz'(1);
      rc_cnt_q  <= rc_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (issue) begin
      s1_start_q <= start_a[gnt_idx];
      s1_end_q   <= end_a[gnt_idx];
      s1_port_q  <= gnt_idx;
    end
    fwd_data_q <= new_cnt;
    if (push) begin
      rc_start_mem[rc_wr_q] <= s1_start_q;
      rc_end_mem[rc_wr_q]   <= s1_end_q;
    end
  end

endmodule

// File: tb/tb_llmanager_refcount_mp.sv
// Directed bench for llmanager_refcount_mp: scoreboard queues of expected RAM writes,
// reclaim entries and underflow ports, filled at stimulus time and drained by a monitor.
module tb_llmanager_refcount_mp;
  localparam int LPSZ = 8, REFSZ = 3, PORTS = 4, PORTSZ = 2, RCDEPTH = 4, RCASZ = 2;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [PORTS-1:0]      drq_srdy;
  logic [PORTS-1:0]      drq_drdy;
  logic [PORTS*LPSZ-1:0] drq_start_page, drq_end_page;
  logic                  reclaim_srdy, reclaim_drdy;
  logic [LPSZ-1:0]       reclaim_start_page, reclaim_end_page;
  logic                  refup_srdy, refup_drdy;
  logic [LPSZ-1:0]       refup_page;
  logic [REFSZ-1:0]      refup_count;
  logic                  ref_wr_en, ref_rd_en;
  logic [LPSZ-1:0]       ref_wr_addr, ref_rd_addr;
  logic [REFSZ-1:0]      ref_wr_data;
  logic [REFSZ-1:0]      ref_rd_data = '0;
  logic                  deref_err;
  logic [PORTSZ-1:0]     deref_err_port;

  always #5 clk = ~clk;

  llmanager_refcount_mp #(
    .lpsz(LPSZ), .refsz(REFSZ), .ports(PORTS), .portsz(PORTSZ), .rcdepth(RCDEPTH), .rcasz(RCASZ)
  ) dut (
    .clk(clk), .reset(reset),
    .drq_srdy(drq_srdy), .drq_drdy(drq_drdy),
    .drq_start_page(drq_start_page), .drq_end_page(drq_end_page),
    .reclaim_srdy(reclaim_srdy), .reclaim_drdy(reclaim_drdy),
    .reclaim_start_page(reclaim_start_page), .reclaim_end_page(reclaim_end_page),
    .refup_srdy(refup_srdy), .refup_drdy(refup_drdy),
    .refup_page(refup_page), .refup_count(refup_count),
    .ref_wr_en(ref_wr_en), .ref_wr_addr(ref_wr_addr), .ref_wr_data(ref_wr_data),
    .ref_rd_en(ref_rd_en), .ref_rd_addr(ref_rd_addr), .ref_rd_data(ref_rd_data),
    .deref_err(deref_err), .deref_err_port(deref_err_port)
  );

  // Read-first refcount RAM with one cycle read latency
  logic [REFSZ-1:0] ram [256];
  always @(posedge clk) begin
    if (ref_wr_en === 1'b1) ram[ref_wr_addr] <= ref_wr_data;
    if (ref_rd_en === 1'b1) ref_rd_data <= ram[ref_rd_addr];
  end

  int checks = 0;
  int failures = 0;
  int mcnt [256];
  logic [31:0] exp_wr[$];
  logic [31:0] exp_rc[$];
  logic [31:0] exp_err[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  always @(negedge clk) begin
    if (ref_wr_en === 1'b1) begin
      if (exp_wr.size() == 0) chk("wr_extra", {20'b0, ref_wr_addr, 1'b0, ref_wr_data}, 32'hFFFF_FFFF);
      else chk("wr", {20'b0, ref_wr_addr, 1'b0, ref_wr_data}, exp_wr.pop_front());
    end
    if (reclaim_srdy === 1'b1 && reclaim_drdy === 1'b1) begin
      if (exp_rc.size() == 0) chk("rc_extra", {16'b0, reclaim_start_page, reclaim_end_page}, 32'hFFFF_FFFF);
      else chk("reclaim", {16'b0, reclaim_start_page, reclaim_end_page}, exp_rc.pop_front());
    end
    if (deref_err === 1'b1) begin
      if (exp_err.size() == 0) chk("err_extra", 32'(deref_err_port), 32'hFFFF_FFFF);
      else chk("err_port", 32'(deref_err_port), exp_err.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic set_port(input int p, input logic v, input logic [7:0] s, input logic [7:0] e);
    drq_srdy[p] = v;
    drq_start_page[p*LPSZ +: LPSZ] = s;
    drq_end_page[p*LPSZ +: LPSZ] = e;
  endtask

  task automatic refup(input logic v, input logic [7:0] pg, input logic [2:0] c);
    refup_srdy = v;
    refup_page = pg;
    refup_count = c;
  endtask

  task automatic exp_refup(input logic [7:0] pg, input logic [2:0] c);
    mcnt[pg] = int'(c);
    exp_wr.push_back({20'b0, pg, 1'b0, c});
  endtask

  task automatic exp_deref(input logic [7:0] pg, input logic [7:0] e, input int port);
    if (mcnt[pg] == 0) exp_err.push_back(32'(port));
    else begin
      mcnt[pg] = mcnt[pg] - 1;
      exp_wr.push_back({20'b0, pg, 1'b0, 3'(mcnt[pg])});
      if (mcnt[pg] == 0) exp_rc.push_back({16'b0, pg, e});
    end
  endtask

  task automatic idle(input int n);
    drq_srdy = '0;
    refup_srdy = 1'b0;
    repeat (n) tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b0;
    reclaim_drdy = 1'b1;
    drq_srdy = '1;
    drq_start_page = '0;
    drq_end_page = '0;
    refup(1'b1, 8'd3, 3'd1);
    tick();
    neg();
    chk("rst_drq_drdy", 32'(drq_drdy), 0);
    chk("rst_refup_drdy", 32'(refup_drdy), 0);
    chk("rst_rd_en", 32'(ref_rd_en), 0);
    chk("rst_rd_addr", 32'(ref_rd_addr), 0);
    chk("rst_wr_en", 32'(ref_wr_en), 0);
    chk("rst_reclaim_srdy", 32'(reclaim_srdy), 0);
    chk("rst_deref_err", 32'(deref_err), 0);
    tick();
    idle(0);
    reset = 1'b1;
    tick();

    // reset while a deref sits in S1
    refup(1'b1, 8'd20, 3'd2);
    exp_refup(8'd20, 3'd2);
    neg();
    chk("mid_refup_drdy", 32'(refup_drdy), 1);
    tick();
    refup(1'b0, 8'd0, 3'd0);
    set_port(0, 1'b1, 8'd20, 8'd21);
    neg();
    chk("mid_grant", 32'(drq_drdy), 1);
    tick();
    reset = 1'b0;
    refup(1'b1, 8'd20, 3'd5);
    neg();
    chk("mid_rst_drq_drdy", 32'(drq_drdy), 0);
    chk("mid_rst_wr_en", 32'(ref_wr_en), 0);
    chk("mid_rst_rd_en", 32'(ref_rd_en), 0);
    chk("mid_rst_refup_drdy", 32'(refup_drdy), 0);
    chk("mid_rst_deref_err", 32'(deref_err), 0);
    tick();
    idle(0);
    reset = 1'b1;
    tick();
    neg();
    chk("post_rst_reclaim_srdy", 32'(reclaim_srdy), 0);
    chk("post_rst_wr_en", 32'(ref_wr_en), 0);
    tick();

    // round-robin across four ports, then refup behind a busy S1
    for (int i = 0; i < 4; i++) begin
      refup(1'b1, 8'(40 + i), 3'd2);
      exp_refup(8'(40 + i), 3'd2);
      neg();
      chk("rr_refup_drdy", 32'(refup_drdy), 1);
      tick();
    end
    refup(1'b0, 8'd0, 3'd0);
    for (int i = 0; i < 4; i++) set_port(i, 1'b1, 8'(40 + i), 8'(50 + i));
    for (int c = 0; c < 5; c++) begin
      exp_deref(8'(40 + (c % 4)), 8'(50 + (c % 4)), c % 4);
      neg();
      chk("rr_grant", 32'(drq_drdy), 32'(1) << (c % 4));
      tick();
    end
    drq_srdy = '0;
    refup(1'b1, 8'd60, 3'd1);
    neg();
    chk("refup_wait_drdy", 32'(refup_drdy), 0);
    tick();
    drq_srdy = '1;
    exp_refup(8'd60, 3'd1);
    neg();
    chk("refup_win_drdy", 32'(refup_drdy), 1);
    chk("refup_win_drq", 32'(drq_drdy), 0);
    tick();
    refup(1'b0, 8'd0, 3'd0);
    exp_deref(8'd41, 8'd51, 1);
    neg();
    chk("after_refup_grant", 32'(drq_drdy), 32'h2);
    tick();
    idle(3);

    // back-to-back derefs of one page through the forwarding path
    refup(1'b1, 8'd5, 3'd3);
    exp_refup(8'd5, 3'd3);
    neg();
    chk("p5_refup_drdy", 32'(refup_drdy), 1);
    tick();
    refup(1'b0, 8'd0, 3'd0);
    set_port(0, 1'b1, 8'd5, 8'd7);
    for (int k = 0; k < 3; k++) begin
      exp_deref(8'd5, 8'd7, 0);
      neg();
      chk("p5_grant", 32'(drq_drdy), 1);
      if (k > 0) chk("p5_wr_en", 32'(ref_wr_en), 1);
      tick();
    end
    set_port(0, 1'b0, 8'd5, 8'd7);
    neg();
    chk("p5_idle_drdy", 32'(drq_drdy), 0);
    chk("p5_last_wr_en", 32'(ref_wr_en), 1);
    tick();
    idle(3);

    // underflow on a zero count, with a following deref proceeding
    refup(1'b1, 8'd9, 3'd0);
    exp_refup(8'd9, 3'd0);
    neg();
    chk("p9_refup_drdy", 32'(refup_drdy), 1);
    tick();
    refup(1'b0, 8'd0, 3'd0);
    set_port(2, 1'b1, 8'd9, 8'd19);
    exp_deref(8'd9, 8'd19, 2);
    neg();
    chk("p9_grant", 32'(drq_drdy), 32'h4);
    tick();
    set_port(2, 1'b0, 8'd9, 8'd19);
    set_port(3, 1'b1, 8'd42, 8'd52);
    exp_deref(8'd42, 8'd52, 3);
    neg();
    chk("err_next_grant", 32'(drq_drdy), 32'h8);
    chk("err_pulse", 32'(deref_err), 1);
    chk("err_port_direct", 32'(deref_err_port), 2);
    chk("err_no_write", 32'(ref_wr_en), 0);
    tick();
    set_port(3, 1'b0, 8'd42, 8'd52);
    neg();
    chk("err_after_wr_en", 32'(ref_wr_en), 1);
    chk("err_one_cycle", 32'(deref_err), 0);
    tick();
    idle(3);

    // reclaim back-pressure fills the FIFO and throttles issue
    reclaim_drdy = 1'b0;
    for (int i = 0; i < 8; i++) begin
      refup(1'b1, 8'(100 + i), 3'd1);
      exp_refup(8'(100 + i), 3'd1);
      neg();
      chk("stall_refup_drdy", 32'(refup_drdy), 1);
      tick();
    end
    refup(1'b0, 8'd0, 3'd0);
    for (int k = 0; k < 7; k++) begin
      int pg;
      pg = 100 + ((k < 4) ? k : 4);
      set_port(1, 1'b1, 8'(pg), 8'(pg + 100));
      if (k < 4) exp_deref(8'(pg), 8'(pg + 100), 1);
      neg();
      chk("stall_grant", 32'(drq_drdy), (k < 4) ? 32'h2 : 32'h0);
      if (k == 6) chk("stall_reclaim_srdy", 32'(reclaim_srdy), 1);
      tick();
    end
    reclaim_drdy = 1'b1;
    for (int k = 0; k < 5; k++) begin
      int pg;
      pg = 104 + ((k > 0) ? k - 1 : 0);
      set_port(1, 1'b1, 8'(pg), 8'(pg + 100));
      if (k > 0) exp_deref(8'(pg), 8'(pg + 100), 1);
      neg();
      chk("resume_grant", 32'(drq_drdy), (k > 0) ? 32'h2 : 32'h0);
      tick();
    end
    set_port(1, 1'b0, 8'd0, 8'd0);
    n = 0;
    while (reclaim_srdy !== 1'b0 && n < 40) begin
      tick();
      n++;
    end
    chk("drain_empty", 32'(reclaim_srdy), 0);
    idle(2);

    // refup and deref of the same page in the same cycle
    refup(1'b1, 8'd70, 3'd2);
    set_port(0, 1'b1, 8'd70, 8'd71);
    exp_refup(8'd70, 3'd2);
    neg();
    chk("same_refup_drdy", 32'(refup_drdy), 1);
    chk("same_drq_blocked", 32'(drq_drdy), 0);
    tick();
    refup(1'b0, 8'd0, 3'd0);
    exp_deref(8'd70, 8'd71, 0);
    neg();
    chk("same_grant_next", 32'(drq_drdy), 1);
    tick();
    set_port(0, 1'b0, 8'd0, 8'd0);
    idle(4);

    chk("wr_queue_empty", 32'(exp_wr.size()), 0);
    chk("rc_queue_empty", 32'(exp_rc.size()), 0);
    chk("err_queue_empty", 32'(exp_err.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
